alu_req_scheduler: RTL and testbench

//  Shares one combinational 8-bit ALU (add/sub/mul, sel-encoded) between two requesters.
//  - Round-robin arbitration; one accepted op at a time.
//  - Operands held stable on the ALU for LATENCY cycles, then the result is registered.
//  - Result returned on a valid/ready response channel, tagged with the requester id.

---
 rtl/alu_req_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// Two-requester round-robin front end for a shared combinational 8-bit ALU; one op in flight at a time.
// Define ALU_SCHED_STATS_EN to add the per-requester grant counters (gnt_cnt0/gnt_cnt1).
module alu_req_scheduler #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic [1:0]        req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,
    input  logic [1:0]        req1_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [1:0]        alu_sel,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_carry,
    output logic              rsp_err,
`ifdef ALU_SCHED_STATS_EN
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              cin_q, cin_d;
    logic [1:0]        sel_q, sel_d;
    logic              id_q, id_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic              err_q, err_d;

    logic              gnt_id;
    logic              accept;
    logic [DATA_W-1:0] op_a, op_b;
    logic              op_cin;
    logic [1:0]        op_sel;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters see ready only in IDLE and only for the granted side; the response holds
    // all rsp_* stable from rsp_valid rising until the edge where rsp_ready is also high.
    always_comb begin
        if (req0_valid && req1_valid) gnt_id = ~last_gnt_q;
        else                          gnt_id = ~req0_valid;
    end

    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    assign op_a   = gnt_id ? req1_a   : req0_a;
    assign op_b   = gnt_id ? req1_b   : req0_b;
    assign op_cin = gnt_id ? req1_cin : req0_cin;
    assign op_sel = gnt_id ? req1_sel : req0_sel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        sel_d      = sel_q;
        id_d       = id_q;
        res_d      = res_q;
        carry_d    = carry_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    cin_d      = op_cin;
                    sel_d      = op_sel;
                    id_d       = gnt_id;
                    last_gnt_d = gnt_id;
                    if (op_sel == SEL_ILLEGAL) begin
                        // Illegal ops skip the ALU and answer with an error immediately.
                        res_d   = '0;
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_result;
                    carry_d = alu_carry;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            sel_q      <= '0;
            id_q       <= 1'b0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            sel_q      <= sel_d;
            id_q       <= id_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cin    = cin_q;
    assign alu_sel    = sel_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_err    = err_q;
    assign dbg_state  = state_q;

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt1_q;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            if (req0_valid && req0_ready) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
            if (req1_valid && req1_ready) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the scheduler.
module tb_alu_req_scheduler;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        v     [2];
    logic [7:0]  ra    [2];
    logic [7:0]  rb    [2];
    logic        rcin  [2];
    logic [1:0]  rs    [2];
    logic        req0_ready, req1_ready;
    logic [7:0]  alu_a, alu_b;
    logic        alu_cin;
    logic [1:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
    logic [15:0] rsp_result;
    logic [1:0]  dbg_state;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    alu_req_scheduler #(.DATA_W(8), .RES_W(16), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]),
        .req0_cin(rcin[0]), .req0_sel(rs[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]),
        .req1_cin(rcin[1]), .req1_sel(rs[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
`ifdef ALU_SCHED_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: returns {carry, result}. The illegal encoding yields junk so that
    // leaking ALU output into an error response is visible.
    function automatic logic [16:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic [1:0] sel);
        logic [8:0] s;
        case (sel)
            2'd0: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; return {s[8], 8'h00, s[7:0]}; end
            2'd1: begin s = {1'b0, a} - {1'b0, b}; return {s[8], 8'h00, s[7:0]}; end
            2'd2: return {1'b0, 16'({8'h00, a} * {8'h00, b})};
            default: return 17'h1ABCD;
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_cin, alu_sel);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: at most one op outstanding; a response becomes visible a
    // fixed number of cycles after acceptance and leaves once the consumer takes it.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [1:0] sel;
    } op_t;

    op_t         m_op;
    bit          m_busy = 0;
    bit          m_last = 1;
    bit          m_id   = 0;
    int          m_wait = 0;
    int          m_g;
    int          acc_cnt [2] = '{0, 0};
    logic [16:0] m_exp;

    always @(negedge clk) begin
        if (rst) begin
            m_busy     = 0;
            m_last     = 1;
            m_wait     = 0;
            acc_cnt[0] = 0;
            acc_cnt[1] = 0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_alu_a", alu_a, 0);
        end else if (m_busy) begin
            if (m_wait > 0) m_wait--;
            chk("busy_req0_ready", req0_ready, 0);
            chk("busy_req1_ready", req1_ready, 0);
            chk("rsp_valid", rsp_valid, m_wait == 0);
            chk("alu_a", alu_a, m_op.a);
            chk("alu_b", alu_b, m_op.b);
            chk("alu_cin", alu_cin, m_op.cin);
            chk("alu_sel", alu_sel, m_op.sel);
            if (m_wait == 0) begin
                m_exp = (m_op.sel == 2'd3) ? 17'h0 : alu_fn(m_op.a, m_op.b, m_op.cin, m_op.sel);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_result", rsp_result, m_exp[15:0]);
                chk("rsp_carry", rsp_carry, m_exp[16]);
                chk("rsp_err", rsp_err, m_op.sel == 2'd3);
                if (rsp_ready) m_busy = 0;
            end
        end else begin
            if (v[0] && v[1]) m_g = m_last ? 0 : 1;
            else if (v[0])    m_g = 0;
            else if (v[1])    m_g = 1;
            else              m_g = -1;
            chk("idle_req0_ready", req0_ready, m_g == 0);
            chk("idle_req1_ready", req1_ready, m_g == 1);
            chk("idle_rsp_valid", rsp_valid, 0);
            if (m_g >= 0) begin
                m_busy  = 1;
                m_last  = m_g[0];
                m_id    = m_g[0];
                m_op.a   = ra[m_g];
                m_op.b   = rb[m_g];
                m_op.cin = rcin[m_g];
                m_op.sel = rs[m_g];
                m_wait  = (rs[m_g] == 2'd3) ? 1 : LAT + 1;
                acc_cnt[m_g]++;
            end
        end
    end

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [1:0] sel);
        ra[i] = a; rb[i] = b; rcin[i] = cin; rs[i] = sel;
    endtask

    task automatic rand_op(input int i);
        set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    endtask

    // Waits (bounded) for requester i to be ready at a sample point; returns the cycle seen.
    task automatic wait_ready(input string name, input int i, output int t);
        bit got = 0;
        t = -1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if ((i == 0 && req0_ready) || (i == 1 && req1_ready)) begin
                got = 1;
                t = cyc;
            end
        end
        chk(name, got, 1);
    endtask

    task automatic wait_rsp(input string name, input logic eid, input logic [15:0] eres,
                            input logic ecarry, input logic eerr, output int t);
        bit got = 0;
        t = -1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                t = cyc;
            end
        end
        chk({name, "_seen"}, got, 1);
        chk({name, "_id"}, rsp_id, eid);
        chk({name, "_result"}, rsp_result, eres);
        chk({name, "_carry"}, rsp_carry, ecarry);
        chk({name, "_err"}, rsp_err, eerr);
    endtask

    task automatic drain();
        v[0] = 0;
        v[1] = 0;
        rsp_ready = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!rsp_valid && dbg_state == 2'd0) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_op(input string name, input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [1:0] sel, input logic [15:0] eres,
                         input logic ecarry, input logic eerr, input int edelay);
        int ta, tr;
        set_op(i, a, b, cin, sel);
        v[i] = 1;
        wait_ready({name, "_accept"}, i, ta);
        @(posedge clk); #1;
        v[i] = 0;
        wait_rsp(name, i[0], eres, ecarry, eerr, tr);
        chk({name, "_delay"}, tr - ta, edelay);
        @(posedge clk); #1;
    endtask

    int ids [$];
    logic [15:0] ress [$];
    int t0, t1;
    int seen [2];

    initial begin
        rst = 1;
        rsp_ready = 1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 0;
            set_op(i, 8'h00, 8'h00, 1'b0, 2'd0);
        end
        @(negedge clk);
        chk("reset_state", dbg_state, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_alu_sel", alu_sel, 0);
        chk("reset_req0_ready", req0_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Single add from req0, then an illegal op from req1.
        do_op("t1_add", 0, 8'h0F, 8'h01, 1'b0, 2'd0, 16'h0010, 1'b0, 1'b0, LAT + 1);
        do_op("t4_illegal", 1, 8'hAA, 8'h55, 1'b0, 2'd3, 16'h0000, 1'b0, 1'b1, 1);

        // Both held valid: grants must alternate starting with req0.
        set_op(0, 8'h05, 8'h03, 1'b0, 2'd1);
        set_op(1, 8'h10, 8'h10, 1'b0, 2'd2);
        v[0] = 1;
        v[1] = 1;
        for (int k = 0; k < 100 && ids.size() < 4; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                ids.push_back(int'(rsp_id));
                ress.push_back(rsp_result);
            end
        end
        chk("t2_count", ids.size(), 4);
        for (int k = 0; k < ids.size(); k++) begin
            chk("t2_id", ids[k], k % 2);
            chk("t2_result", ress[k], (k % 2 == 0) ? 16'h0002 : 16'h0100);
        end
        @(posedge clk); #1;
        drain();

        // Back-pressure on the response for five cycles.
        rsp_ready = 0;
        set_op(0, 8'h80, 8'h80, 1'b1, 2'd0);
        v[0] = 1;
        wait_ready("t3_accept", 0, t0);
        @(posedge clk); #1;
        v[0] = 0;
        set_op(1, 8'h09, 8'h04, 1'b0, 2'd1);
        v[1] = 1;
        wait_rsp("t3_hold", 1'b0, 16'h0001, 1'b1, 1'b0, t1);
        chk("t3_delay", t1 - t0, LAT + 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t3_stall_valid", rsp_valid, 1);
            chk("t3_stall_result", rsp_result, 16'h0001);
            chk("t3_stall_ready0", req0_ready, 0);
            chk("t3_stall_ready1", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        chk("t3_hs_valid", rsp_valid, 1);
        chk("t3_hs_bubble", req1_ready, 0);
        @(negedge clk);
        chk("t3_after_valid", rsp_valid, 0);
        chk("t3_after_ready1", req1_ready, 1);
        @(posedge clk); #1;
        v[1] = 0;
        wait_rsp("t3_req1", 1'b1, 16'h0005, 1'b0, 1'b0, t1);
        @(posedge clk); #1;
        drain();

        // Reset in the middle of a req1 op.
        set_op(1, 8'h03, 8'h07, 1'b0, 2'd2);
        v[1] = 1;
        wait_ready("t5_accept", 1, t0);
        @(posedge clk); #1;
        v[1] = 0;
        @(posedge clk); #1;
        rst = 1;
        set_op(0, 8'h20, 8'h22, 1'b1, 2'd0);
        set_op(1, 8'h09, 8'h02, 1'b0, 2'd1);
        v[0] = 1;
        v[1] = 1;
        @(negedge clk);
        chk("t5_abort_valid", rsp_valid, 0);
        chk("t5_abort_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("t5_first_gnt0", req0_ready, 1);
        chk("t5_first_gnt1", req1_ready, 0);
        @(posedge clk); #1;
        v[0] = 0;
        wait_rsp("t5_rsp", 1'b0, 16'h0043, 1'b0, 1'b0, t1);
        wait_ready("t5_req1_accept", 1, t0);
        @(posedge clk); #1;
        v[1] = 0;
        wait_rsp("t5_req1_rsp", 1'b1, 16'h0007, 1'b0, 1'b0, t1);
        @(posedge clk); #1;
        drain();

        // Random traffic, checked cycle by cycle by the model.
        seen[0] = acc_cnt[0];
        seen[1] = acc_cnt[1];
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc_cnt[i] != seen[i]) begin
                    seen[i] = acc_cnt[i];
                    v[i] = 1'($urandom_range(0, 1));
                    if (v[i]) rand_op(i);
                end else if (!v[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        rand_op(i);
                        v[i] = 1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    v[i] = 0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        drain();

`ifdef ALU_SCHED_STATS_EN
        chk("gnt_cnt0", gnt_cnt0, acc_cnt[0] & 32'hFFFF);
        chk("gnt_cnt1", gnt_cnt1, acc_cnt[1] & 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
